// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch unit: FSM encoding, instruction width, FIFO entry.
// No logic here.
package ifetch_pkg;

    localparam int          INST_W   = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of {pc, inst}; head is read straight from the entry registers.
// Latency: write at edge N visible at head after edge N; no bypass.
// Backpressure: push ignored when full, pop ignored when empty; flush empties it in one edge.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_t        wr_dat,
    input  logic          pop,
    output fetch_t        rd_dat,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_dat  = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_dat;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: word-address requests to instruction memory, prefetch FIFO to decode. Optional: IFU_MISALIGN_CHK_EN.
// Latency: memory accept at edge N -> inst_valid from cycle N+1; redirect -> new-target request next cycle.
// Backpressure: mem_en drops when the FIFO is full; mem_ready low holds the request stable.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [31:0]       mem_addr,
    output logic              mem_en,
    input  logic              mem_ready,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              redir_valid,
    input  logic [31:0]       redir_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [31:0]       inst_pc,
    output logic              ifu_fault
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   redir_tgt;
    logic          fetch_done;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_t        fifo_head;

    // Low address bits are masked rather than sliced so a misaligned target lands on its word.
    assign redir_tgt  = redir_pc & ~32'h3;

    // Request depends only on registered state, never on mem_ready or inst_ready.
    assign mem_en     = (state_q == S_RUN) && (fifo_count < DEPTH_C);
    assign mem_addr   = pc_q;
    assign fetch_done = mem_en && mem_ready;
    assign fifo_push  = fetch_done && !redir_valid && !fifo_full;
    assign fifo_pop   = inst_valid && inst_ready && !redir_valid;
    assign inst_valid = !fifo_empty;
    assign inst_data  = fifo_head.inst;
    assign inst_pc    = fifo_head.pc;

`ifdef IFU_MISALIGN_CHK_EN
    logic fault_q, fault_d;
    assign ifu_fault = fault_q;
`else
    assign ifu_fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef IFU_MISALIGN_CHK_EN
        fault_d = fault_q;
`endif
        if (redir_valid) begin
            pc_d    = redir_tgt;
            state_d = S_RUN;
`ifdef IFU_MISALIGN_CHK_EN
            fault_d = 1'b0;
            if (redir_pc[1:0] != 2'b00) begin
                state_d = S_FAULT;
                fault_d = 1'b1;
            end
`endif
        end else begin
            case (state_q)
                S_BOOT:  state_d = S_RUN;
                S_RUN:   if (fetch_done) pc_d = pc_q + 32'd4;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
`ifdef IFU_MISALIGN_CHK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef IFU_MISALIGN_CHK_EN
            fault_q <= fault_d;
`endif
        end
    end

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (redir_valid),
        .push   (fifo_push),
        .wr_dat ('{pc: pc_q, inst: mem_rdata}),
        .pop    (fifo_pop),
        .rd_dat (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

endmodule
